fp_addsub_seq: RTL and testbench



---
 rtl/addpkg.sv | 37 +++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_addsub_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/addpkg.sv
// addpkg: shared types and constants for the sequential FP add/sub engine
package addpkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_INVALID,
      ERR_OVERFLOW,
      ERR_UNDERFLOW
   } o_err_t;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_DENORM,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } cls_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC00000;

   function automatic cls_t classify(input logic ez, input logic emax, input logic fz);
      return ez ? (fz ? CLS_ZERO : CLS_DENORM) : emax ? (fz ? CLS_INF : CLS_NAN) : CLS_NORM;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter, returns W for an all-zero input
module fp_lzc #(
   parameter int W  = 28,
   parameter int ZW = $clog2(W + 1)
) (
   input  logic [W-1:0]  a,
   output logic [ZW-1:0] z
);

   // Scan upward so the highest set bit wins
   always_comb begin
      z = ZW'(W);
      for (int i = 0; i < W; i++)
         if (a[i]) z = ZW'(W - 1 - i);
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle handshaked binary32 add/subtract engine
module fp_addsub_seq
   import addpkg::*;
#(
   parameter int EXP_BITS = 8,
   parameter int SIG_BITS = 23,
   parameter int GRS_BITS = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         opcode,
   input  logic                         sign1,
   input  logic                         sign2,
   input  logic [EXP_BITS-1:0]          exp1,
   input  logic [EXP_BITS-1:0]          exp2,
   input  logic [SIG_BITS-1:0]          sig1,
   input  logic [SIG_BITS-1:0]          sig2,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_BITS+SIG_BITS:0]   fp_out,
   output o_err_t                       err_o
);

   localparam int M  = SIG_BITS + 1;
   localparam int W  = M + GRS_BITS;
   localparam int S  = W + 1;
   localparam int FW = 1 + EXP_BITS + SIG_BITS;
   localparam int EW = EXP_BITS + 1;
   localparam int ZW = $clog2(S + 1);
   localparam logic [EW-1:0] ONE_E = EW'(1);

   state_t state, nxt;

   logic                r_op, r_s1, r_s2;
   logic [EXP_BITS-1:0] r_e1, r_e2;
   logic [SIG_BITS-1:0] r_f1, r_f2;

   logic                u_s1, u_s2;
   logic [EXP_BITS-1:0] u_e1, u_e2;
   logic [M-1:0]        u_m1, u_m2;
   cls_t                u_c1, u_c2;

   logic                a_s, a_sub, a_zs, sp_v, sp_inv, sp_s;
   logic [EXP_BITS-1:0] a_e;
   logic [W-1:0]        a_x, a_y;

   logic [S-1:0]        d_sum;

   logic [W-1:0]        n_m;
   logic [EW-1:0]       n_e;
   logic                n_nz;

   logic                h1, h2;
   logic                swap, xs, ys, nan, i1, i2;
   logic [EXP_BITS-1:0] xe, ye, dif;
   logic [M-1:0]        xm, ym;
   logic [W-1:0]        ext, shr;
   logic                stk;

   logic [S-1:0]        sum;

   logic [ZW-1:0]       lz;
   logic                cy;
   logic [EW-1:0]       zm1, lim, sh;
   logic [W-1:0]        nm;
   logic [EW-1:0]       ne;

   logic                inc, ovf, uf, sgn;
   logic [M:0]          rm;
   logic [M-1:0]        mant;
   logic [EW-1:0]       re, ef;
   logic [FW-1:0]       fin, res;
   o_err_t              err;

   // Control state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= nxt;

   // Fixed one-cycle-per-stage sequence with handshake outputs
   always_comb begin
      nxt       = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nxt = S_UNPACK;
         end
         S_UNPACK: nxt = S_ALIGN;
         S_ALIGN:  nxt = S_ADD;
         S_ADD:    nxt = S_NORM;
         S_NORM:   nxt = S_ROUND;
         S_ROUND:  nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = S_IDLE;
         end
         default:  nxt = S_IDLE;
      endcase
   end

   assign h1 = |r_e1;
   assign h2 = |r_e2;

   assign swap = {u_e2, u_m2} > {u_e1, u_m1};
   assign xs   = swap ? u_s2 : u_s1;
   assign ys   = swap ? u_s1 : u_s2;
   assign xe   = swap ? u_e2 : u_e1;
   assign ye   = swap ? u_e1 : u_e2;
   assign xm   = swap ? u_m2 : u_m1;
   assign ym   = swap ? u_m1 : u_m2;
   assign dif  = xe - ye;
   assign ext  = {ym, {GRS_BITS{1'b0}}};
   assign shr  = ext >> dif;
   assign stk  = |(ext & ~({W{1'b1}} << dif));
   assign nan  = (u_c1 == CLS_NAN) || (u_c2 == CLS_NAN);
   assign i1   = u_c1 == CLS_INF;
   assign i2   = u_c2 == CLS_INF;

   assign sum = a_sub ? {1'b0, a_x} - {1'b0, a_y} : {1'b0, a_x} + {1'b0, a_y};

   fp_lzc #(.W(S), .ZW(ZW)) u_lzc (
      .a (d_sum),
      .z (lz)
   );

   assign cy  = d_sum[S-1];
   assign zm1 = EW'(lz) - ONE_E;
   assign lim = {1'b0, a_e} - ONE_E;
   assign sh  = zm1 > lim ? lim : zm1;
   assign nm  = cy ? {d_sum[S-1:2], |d_sum[1:0]} : d_sum[W-1:0] << sh;
   assign ne  = cy ? {1'b0, a_e} + ONE_E : {1'b0, a_e} - sh;

   assign inc  = n_m[GRS_BITS-1] & (|n_m[GRS_BITS-2:0] | n_m[GRS_BITS]);
   assign rm   = {1'b0, n_m[W-1:GRS_BITS]} + {{M{1'b0}}, inc};
   assign mant = rm[M] ? rm[M:1] : rm[M-1:0];
   assign re   = rm[M] ? n_e + ONE_E : n_e;
   assign ef   = mant[M-1] ? re : '0;
   assign ovf  = ef >= EW'(EXP_MAX);
   assign uf   = n_nz && !mant[M-1];
   assign sgn  = n_nz ? a_s : a_zs;
   assign fin  = {sgn, ef[EXP_BITS-1:0], mant[SIG_BITS-1:0]};
   assign res  = sp_v ? (sp_inv ? FW'(QNAN) : {sp_s, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}})
               : ovf  ? {a_s, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}} : fin;
   assign err  = sp_v ? (sp_inv ? ERR_INVALID : ERR_NONE)
               : ovf  ? ERR_OVERFLOW : uf ? ERR_UNDERFLOW : ERR_NONE;

   // Stage registers; each stage loads only in its own state and then holds
   always_ff @(posedge clk) begin
      if (state == S_IDLE && in_valid) begin
         r_op <= opcode;
         r_s1 <= sign1;
         r_s2 <= sign2;
         r_e1 <= exp1;
         r_e2 <= exp2;
         r_f1 <= sig1;
         r_f2 <= sig2;
      end
      if (state == S_UNPACK) begin
         u_s1 <= r_s1;
         u_s2 <= r_s2 ^ r_op;
         u_e1 <= h1 ? r_e1 : EXP_BITS'(1);
         u_e2 <= h2 ? r_e2 : EXP_BITS'(1);
         u_m1 <= {h1, r_f1};
         u_m2 <= {h2, r_f2};
         u_c1 <= classify(!h1, &r_e1, ~|r_f1);
         u_c2 <= classify(!h2, &r_e2, ~|r_f2);
      end
      if (state == S_ALIGN) begin
         a_s    <= xs;
         a_e    <= xe;
         a_sub  <= xs ^ ys;
         a_x    <= {xm, {GRS_BITS{1'b0}}};
         a_y    <= {shr[W-1:1], shr[0] | stk};
         a_zs   <= u_s1 & u_s2;
         sp_v   <= nan | i1 | i2;
         sp_inv <= nan | (i1 & i2 & (u_s1 ^ u_s2));
         sp_s   <= i1 ? u_s1 : u_s2;
      end
      if (state == S_ADD) d_sum <= sum;
      if (state == S_NORM) begin
         n_m  <= nm;
         n_e  <= ne;
         n_nz <= |d_sum;
      end
   end

   // Result and error code, loaded as ROUND completes and held through DONE
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fp_out <= '0;
         err_o  <= ERR_NONE;
      end else if (state == S_ROUND) begin
         fp_out <= res;
         err_o  <= err;
      end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed self-checking bench for fp_addsub_seq
module tb_fp_addsub_seq;
   import addpkg::*;

   logic        clk, rst, in_valid, in_ready, opcode, sign1, sign2;
   logic [7:0]  exp1, exp2;
   logic [22:0] sig1, sig2;
   logic        out_valid, out_ready;
   logic [31:0] fp_out;
   o_err_t      err_o;
   int          checks, failures;

   fp_addsub_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .sign1     (sign1),
      .sign2     (sign2),
      .exp1      (exp1),
      .exp2      (exp2),
      .sig1      (sig1),
      .sig2      (sig2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_out    (fp_out),
      .err_o     (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
      sign1    = a[31];
      exp1     = a[30:23];
      sig1     = a[22:0];
      sign2    = b[31];
      exp2     = b[30:23];
      sig2     = b[22:0];
      opcode   = op;
      in_valid = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge after the output transfer
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] xf, input o_err_t xe);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      drive(a, b, op);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd6);
      chk({tag, "_fp"}, fp_out, xf);
      chk({tag, "_err"}, 32'(err_o), 32'(xe));
      @(negedge clk);
      chk({tag, "_irdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int n;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(32'h0, 32'h0, 1'b0);
      in_valid  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fp_out", fp_out, 32'h0);
      chk("rst_err", 32'(err_o), 32'(ERR_NONE));
      rst = 1'b0;
      @(negedge clk);

      run_op("two_plus_two", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, ERR_NONE);
      run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, ERR_NONE);
      run_op("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, ERR_NONE);
      run_op("max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, ERR_OVERFLOW);
      run_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, ERR_INVALID);
      run_op("den_plus_den", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, ERR_UNDERFLOW);
      run_op("minnorm_minus_den", 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, ERR_UNDERFLOW);
      run_op("tie_even_down", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, ERR_NONE);
      run_op("tie_even_up", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, ERR_NONE);
      run_op("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, ERR_NONE);
      run_op("nan_plus_one", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, ERR_INVALID);
      run_op("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, ERR_NONE);

      out_ready = 1'b0;
      drive(32'h40000000, 32'h40000000, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_lat", 32'(n), 32'd6);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_fp", fp_out, 32'h40800000);
         chk("bp_err", 32'(err_o), 32'(ERR_NONE));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", 32'(in_ready), 32'd1);

      drive(32'h3F800000, 32'h3F800000, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mid_rst_no_result", 32'(out_valid), 32'd0);
      end
      run_op("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, ERR_NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
